// File: rtl/tuner_3.sv
// Digital down-converter: phase accumulator with selectable noise shaping,
// quarter-wave sine LUT and a complex mixer, fixed four-clock latency.
module tuner_3 #(
  parameter int unsigned DSZ = 14,
  parameter int unsigned FSZ = 26,
  parameter int unsigned PSZ = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [DSZ-1:0] in,
  input  logic           in_valid,
  input  logic           cfg_wr,
  input  logic [FSZ-1:0] cfg_frq,
  input  logic [PSZ-1:0] cfg_ofs,
  input  logic           cfg_clr,
  input  logic [1:0]     ns_mode,
  input  logic           q_inv,
  output logic           cfg_pend,
  output logic [DSZ-1:0] i_out,
  output logic [DSZ-1:0] q_out,
  output logic           out_valid
);

  localparam int unsigned RSZ = FSZ - PSZ;
  localparam int unsigned QSZ = PSZ - 2;
  localparam int unsigned QN  = 1 << QSZ;
  localparam int unsigned PW  = 2 * DSZ;
  localparam real         AMP = real'((1 << (DSZ - 1)) - 1);
  localparam logic signed [PW-1:0] RND  = PW'(1) <<< (DSZ - 2);
  localparam logic signed [PW-1:0] MAXV = (PW'(1) <<< (DSZ - 1)) - PW'(1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

  // Quarter-wave table, entry k = round(AMP * sin(2*pi*k / 2^PSZ)), k = 0..QN
  logic signed [DSZ-1:0] lut [QN+1];
  for (genvar k = 0; k <= QN; k++) begin : g_lut
    localparam real ANG = 6.283185307179586 * k / (4.0 * QN);
    localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
    assign lut[k] = DSZ'(VAL);
  end

  logic [FSZ-1:0] acc, frq_act, pend_frq;
  logic [PSZ-1:0] ofs_act, pend_ofs;
  logic           pend_clr;
  logic [RSZ-1:0] res;
  logic [31:0]    lfsr, lfsr_nx;
  logic [FSZ-1:0] ns_val;
  logic [PSZ-1:0] top_sel, idx;

  // Phase index for the sample presented this cycle
  always_comb begin
    ns_val  = acc + {{PSZ{res[RSZ-1]}}, res};
    lfsr_nx = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0000_0000);
    case (ns_mode)
      2'd1:    top_sel = ns_val[FSZ-1 -: PSZ];
      2'd2:    top_sel = PSZ'((acc + FSZ'(lfsr[RSZ-1:0])) >> RSZ);
      default: top_sel = acc[FSZ-1 -: PSZ];
    endcase
    idx = top_sel + ofs_act;
  end

  // Accumulator, shaping state and double-buffered configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      frq_act  <= '0;
      ofs_act  <= '0;
      pend_frq <= '0;
      pend_ofs <= '0;
      pend_clr <= 1'b0;
      cfg_pend <= 1'b0;
      res      <= '0;
      lfsr     <= 32'h0000_0001;
    end else begin
      if (in_valid) begin
        lfsr <= lfsr_nx;
        res  <= (ns_mode == 2'd1) ? ns_val[RSZ-1:0] : '0;
        if (cfg_pend) begin
          frq_act  <= pend_frq;
          ofs_act  <= pend_ofs;
          cfg_pend <= 1'b0;
          acc      <= pend_clr ? '0 : acc + frq_act;
        end else begin
          acc <= acc + frq_act;
        end
      end
      // A coincident write re-arms the pending slot after the apply above
      if (cfg_wr) begin
        pend_frq <= cfg_frq;
        pend_ofs <= cfg_ofs;
        pend_clr <= cfg_clr;
        cfg_pend <= 1'b1;
      end
    end
  end

  logic                  v1, v2, v3;
  logic [PSZ-1:0]        ph1;
  logic signed [DSZ-1:0] x1, x2, cos2, sin2;
  logic                  qi1;
  logic signed [PW-1:0]  pi3, pq3;

  logic [1:0]            quad;
  logic [QSZ:0]          a_f, a_r;
  logic signed [DSZ-1:0] l_f, l_r, sin_v, cos_v;

  // Quadrant mirroring of the quarter-wave table
  always_comb begin
    quad = ph1[PSZ-1 -: 2];
    a_f  = {1'b0, ph1[QSZ-1:0]};
    a_r  = (QSZ+1)'(QN) - a_f;
    l_f  = lut[a_f];
    l_r  = lut[a_r];
    case (quad)
      2'd0:    begin sin_v =  l_f; cos_v =  l_r; end
      2'd1:    begin sin_v =  l_r; cos_v = -l_f; end
      2'd2:    begin sin_v = -l_f; cos_v = -l_r; end
      default: begin sin_v = -l_r; cos_v =  l_f; end
    endcase
  end

  function automatic logic [DSZ-1:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + RND) >>> (DSZ - 1);
    if (r > MAXV)      return DSZ'(MAXV);
    else if (r < MINV) return DSZ'(MINV);
    else               return DSZ'(r);
  endfunction

  // Four-stage datapath: phase, LUT, multiply, round/saturate
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; out_valid <= 1'b0;
      ph1 <= '0; x1 <= '0; qi1 <= 1'b0;
      x2 <= '0; cos2 <= '0; sin2 <= '0;
      pi3 <= '0; pq3 <= '0;
      i_out <= '0; q_out <= '0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (in_valid) begin
        ph1 <= idx;
        x1  <= in;
        qi1 <= q_inv;
      end
      if (v1) begin
        x2   <= x1;
        cos2 <= cos_v;
        sin2 <= qi1 ? -sin_v : sin_v;
      end
      if (v2) begin
        pi3 <= PW'(x2) * PW'(cos2);
        pq3 <= PW'(x2) * PW'(sin2);
      end
      if (v3) begin
        i_out <= round_sat(pi3);
        q_out <= round_sat(pq3);
      end
    end
  end

endmodule

// File: tb/tb_tuner_3.sv
// Self-checking bench for tuner_3: directed vector table, hand sequences for
// config/reset corners, and a randomized run against a behavioural model.
module tb_tuner_3;

  localparam int DSZ = 14;
  localparam int FSZ = 26;
  localparam int PSZ = 12;
  localparam int RSZ = FSZ - PSZ;
  localparam longint M = longint'(1) << FSZ;
  localparam longint R = longint'(1) << RSZ;
  localparam int N = 1 << PSZ;
  localparam real A = real'((1 << (DSZ - 1)) - 1);

  logic           clk;
  logic           reset;
  logic [DSZ-1:0] din;
  logic           in_valid, cfg_wr, cfg_clr, q_inv;
  logic [FSZ-1:0] cfg_frq;
  logic [PSZ-1:0] cfg_ofs;
  logic [1:0]     ns_mode;
  logic           cfg_pend, out_valid;
  logic [DSZ-1:0] i_out, q_out;

  tuner_3 #(.DSZ(DSZ), .FSZ(FSZ), .PSZ(PSZ)) dut (
    .clk(clk), .reset(reset), .in(din), .in_valid(in_valid),
    .cfg_wr(cfg_wr), .cfg_frq(cfg_frq), .cfg_ofs(cfg_ofs), .cfg_clr(cfg_clr),
    .ns_mode(ns_mode), .q_inv(q_inv), .cfg_pend(cfg_pend),
    .i_out(i_out), .q_out(q_out), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Behavioural model state
  longint m_acc, m_frq, m_pfrq, m_res, m_lfsr;
  int     m_ofs, m_pofs;
  bit     m_pclr, m_pend;
  bit     d_v [1:4];
  int     d_i [1:4];
  int     d_q [1:4];
  int     h_i, h_q;
  int     got_i [64];
  int     got_q [64];
  int     ngot;

  function automatic int amp_round(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // Fixed-point multiply by a table amplitude, then round half up and clamp
  function automatic int mix(input int x, input int c);
    longint p;
    p = longint'(x) * longint'(c) + (longint'(1) << (DSZ - 2));
    p = p >>> (DSZ - 1);
    if (p > (1 << (DSZ - 1)) - 1) p = (1 << (DSZ - 1)) - 1;
    if (p < -(1 << (DSZ - 1)))    p = -(1 << (DSZ - 1));
    return int'(p);
  endfunction

  // Galois LFSR for x^32+x^22+x^2+x+1, shifting toward bit 0
  function automatic longint lfsr_step(input longint l);
    longint mask;
    mask = (longint'(1) << 31) | (longint'(1) << 21) | (longint'(1) << 1) | longint'(1);
    if (l[0]) return (l >> 1) ^ mask;
    return l >> 1;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_frq = 0; m_pfrq = 0; m_res = 0; m_lfsr = 1;
    m_ofs = 0; m_pofs = 0; m_pclr = 0; m_pend = 0;
    for (int k = 1; k <= 4; k++) begin d_v[k] = 0; d_i[k] = 0; d_q[k] = 0; end
    h_i = 0; h_q = 0;
  endtask

  task automatic model_step();
    longint base, nacc, lo;
    int p, s, c, x;
    real ang;
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 4; k >= 2; k--) begin
        d_v[k] = d_v[k-1]; d_i[k] = d_i[k-1]; d_q[k] = d_q[k-1];
      end
      d_v[1] = 0;
      if (in_valid) begin
        case (int'(ns_mode))
          1:       base = (((m_acc + m_res) % M) + M) % M;
          2:       base = (m_acc + (m_lfsr % R)) % M;
          default: base = m_acc;
        endcase
        p   = int'(((base / R) + longint'(m_ofs)) % longint'(N));
        ang = 6.283185307179586 * real'(p) / real'(N);
        s   = amp_round(A * $sin(ang));
        c   = amp_round(A * $cos(ang));
        if (q_inv) s = -s;
        x = int'($signed(din));
        d_v[1] = 1; d_i[1] = mix(x, c); d_q[1] = mix(x, s);
        lo = base % R;
        m_res  = (ns_mode == 2'd1) ? ((lo >= R / 2) ? lo - R : lo) : 0;
        m_lfsr = lfsr_step(m_lfsr);
        nacc   = (m_pend && m_pclr) ? 0 : (m_acc + m_frq) % M;
        if (m_pend) begin m_frq = m_pfrq; m_ofs = m_pofs; m_pend = 0; end
        m_acc = nacc;
      end
      if (cfg_wr) begin
        m_pfrq = longint'(cfg_frq); m_pofs = int'(cfg_ofs); m_pclr = cfg_clr; m_pend = 1;
      end
      if (d_v[4]) begin h_i = d_i[4]; h_q = d_q[4]; end
    end
  endtask

  // One clock: advance the model with the driven inputs, then compare outputs
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    if (out_valid !== d_v[4] || i_out !== DSZ'(h_i) || q_out !== DSZ'(h_q) ||
        cfg_pend !== m_pend) begin
      errors++;
      $display("FAIL model cyc=%0d: got v=%b i=%0d q=%0d pend=%b, want v=%b i=%0d q=%0d pend=%b",
               cyc, out_valid, $signed(i_out), $signed(q_out), cfg_pend,
               d_v[4], h_i, h_q, m_pend);
    end
    if (out_valid === 1'b1 && ngot < 64) begin
      got_i[ngot] = int'($signed(i_out));
      got_q[ngot] = int'($signed(q_out));
      ngot++;
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; cfg_wr = 0; cfg_clr = 0; cfg_frq = '0; cfg_ofs = '0;
    din = '0; q_inv = 0; ns_mode = 2'd0;
  endtask

  typedef struct {
    int din; int frq; int ofs; int mode; int qinv; int idx; int ei; int eq;
  } vec_t;
  vec_t vecs [12];

  initial begin
    model_reset();
    idle_inputs();
    reset = 1;
    tick();
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_i_out", int'($signed(i_out)), 0);
    chk("reset_cfg_pend", int'(cfg_pend), 0);

    // {in, frq, ofs, mode, q_inv, sample index, expected i, expected q}
    vecs[0]  = '{1000, 0,       0,    0, 0, 5, 1000,  0};
    vecs[1]  = '{1000, 1 << 24, 0,    0, 0, 1, 1000,  0};
    vecs[2]  = '{1000, 1 << 24, 0,    0, 0, 2, 0,     1000};
    vecs[3]  = '{1000, 1 << 24, 0,    0, 0, 3, -1000, 0};
    vecs[4]  = '{1000, 1 << 24, 0,    0, 0, 4, 0,     -1000};
    vecs[5]  = '{1000, 1 << 24, 0,    0, 1, 2, 0,     -1000};
    vecs[6]  = '{1000, 0,       1024, 0, 0, 3, 0,     1000};
    vecs[7]  = '{-8192, 0,      0,    0, 0, 2, -8191, 0};
    vecs[8]  = '{8191, 0,       0,    0, 0, 2, 8190,  0};   // 8191*8191 rounds down to 8190
    vecs[9]  = '{1000, 1 << 24, 0,    3, 0, 3, -1000, 0};
    vecs[10] = '{1000, 0,       0,    2, 0, 3, 1000,  0};
    vecs[11] = '{1000, 1 << 24, 0,    1, 0, 2, 0,     1000};

    for (int v = 0; v < 12; v++) begin
      idle_inputs();
      reset = 1; tick(); tick(); reset = 0;
      cfg_wr = 1; cfg_clr = 1; cfg_frq = FSZ'(vecs[v].frq); cfg_ofs = PSZ'(vecs[v].ofs);
      ns_mode = 2'(vecs[v].mode); q_inv = vecs[v].qinv[0];
      tick();
      cfg_wr = 0; ngot = 0;
      din = DSZ'(vecs[v].din); in_valid = 1;
      repeat (vecs[v].idx + 2) tick();
      in_valid = 0;
      repeat (5) tick();
      checks++;
      if (ngot <= vecs[v].idx ||
          got_i[vecs[v].idx] != vecs[v].ei || got_q[vecs[v].idx] != vecs[v].eq) begin
        errors++;
        $display("FAIL vec%0d: got n=%0d i=%0d q=%0d want i=%0d q=%0d", v, ngot,
                 got_i[vecs[v].idx], got_q[vecs[v].idx], vecs[v].ei, vecs[v].eq);
      end
    end

    // Pending config held while idle; second write during apply stays pending
    idle_inputs();
    reset = 1; tick(); reset = 0;
    cfg_wr = 1; cfg_frq = FSZ'(1 << 20); tick(); cfg_wr = 0;
    chk("pend_set", int'(cfg_pend), 1);
    repeat (3) tick();
    chk("pend_held_idle", int'(cfg_pend), 1);
    cfg_wr = 1; cfg_frq = FSZ'(1 << 22); in_valid = 1; din = DSZ'(500); tick();
    cfg_wr = 0;
    chk("pend_after_coincident", int'(cfg_pend), 1);
    tick();
    chk("pend_cleared", int'(cfg_pend), 0);
    in_valid = 0;
    repeat (6) tick();

    // Reset with sparse samples in flight discards them
    idle_inputs();
    reset = 1; tick(); reset = 0;
    ns_mode = 2'd2; cfg_wr = 1; cfg_clr = 1; cfg_frq = FSZ'(1 << 24); tick(); cfg_wr = 0;
    din = DSZ'(3000);
    in_valid = 1; tick(); in_valid = 0; tick(); tick();
    in_valid = 1; tick(); in_valid = 0;
    reset = 1; tick(); tick(); reset = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("flush_out_valid", int'(out_valid), 0);
      chk("flush_i_out", int'($signed(i_out)), 0);
    end

    // Randomized traffic against the model
    idle_inputs();
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 299) == 0);
      in_valid = (n % 500 < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
      din      = DSZ'($urandom_range(0, (1 << DSZ) - 1));
      cfg_wr   = ($urandom_range(0, 24) == 0);
      cfg_frq  = FSZ'($urandom);
      cfg_ofs  = PSZ'($urandom);
      cfg_clr  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) ns_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) q_inv = ~q_inv;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
